instr_mem_loader: RTL and testbench

Boot-time writer for the instruction memory that the core's fetch path and instruction decoder read. It receives a byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes those words sequentially into instruction memory from word address 0 and verifies an XOR checksum. It holds the core in reset until a load completes cleanly.

---
 rtl/instr_mem_loader.sv | 153 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 and holds the core in reset until the XOR checksum matches.
module instr_mem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [23:0] asm_reg;
    logic [7:0]  checksum;

    logic        fire;
    logic        restart;
    logic        last_byte;
    logic        last_word;
    logic [15:0] count_full;
    logic        overflow;

    always_comb begin
        in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                   (state == S_DATA) || (state == S_CHK);
    end

    assign fire       = in_valid && in_ready;
    assign restart    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign last_byte  = (byte_idx == 2'd3);
    assign last_word  = ((word_idx + 16'd1) == word_count);
    assign count_full = {in_data, word_count[7:0]};
    assign overflow   = ({16'h0000, count_full} > CAPACITY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN0;
            end
            S_LEN0: begin
                if (fire) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (fire) begin
                    if (overflow)                 state_next = S_ERROR;
                    else if (count_full == 16'd0) state_next = S_CHK;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (fire && last_byte && last_word) state_next = S_CHK;
            end
            S_CHK: begin
                if (fire) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            asm_reg    <= '0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                done      <= 1'b0;
                error     <= 1'b0;
                checksum  <= '0;
                byte_idx  <= '0;
                word_idx  <= '0;
                imem_addr <= '0;
                cpu_reset <= 1'b1;
            end
            if (fire) begin
                case (state)
                    S_LEN0: word_count <= {8'h00, in_data};
                    S_LEN1: begin
                        word_count[15:8] <= in_data;
                        if (overflow) error <= 1'b1;
                    end
                    S_DATA: begin
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Bytes arrive LSB first, so the first three shift down into asm_reg
                        // and the fourth completes the word directly from in_data.
                        if (last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_WIDTH'(word_idx);
                            imem_wdata <= WIDTH'({in_data, asm_reg});
                            word_idx   <= word_idx + 16'd1;
                        end else begin
                            asm_reg <= {in_data, asm_reg[23:8]};
                        end
                    end
                    S_CHK: begin
                        if (in_data == checksum) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as bytes are driven
// and checked by a write monitor; status outputs are checked inline per scenario.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] payload [0:1023];
    bit          written [0:1023];
    logic [9:0]  last_addr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_mem_loader #(.WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
            written[imem_addr] = 1'b1;
            last_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_two_word();
        payload[0] = 32'h00500093;
        payload[1] = 32'h00108133;
    endtask

    // Sends header, n words from payload and checksum; stop_after>=0 aborts after that many data bytes.
    task automatic send_stream(input int n, input bit gaps, input bit bad,
                               input int start_at, input int stop_after);
        logic [15:0] cnt;
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w32;
        wr_t         e;
        int          idx;
        cnt = 16'(n);
        chk = 8'h00;
        idx = 0;
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        for (int w = 0; w < n; w++) begin
            w32 = payload[w];
            for (int k = 0; k < 4; k++) begin
                if (stop_after >= 0 && idx == stop_after) return;
                b   = w32[8*k +: 8];
                chk = chk ^ b;
                if (k == 3) begin
                    e.addr = 10'(w);
                    e.data = w32;
                    exp_q.push_back(e);
                end
                if (idx == start_at) start = 1'b1;
                send_byte(b);
                start = 1'b0;
                if (gaps) begin
                    in_data = 8'hA5;
                    tick();
                end
                idx++;
            end
        end
        send_byte(bad ? (chk ^ 8'h01) : chk);
    endtask

    task automatic check_drained(input string name);
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_writes=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic d, input logic er,
                                input logic cr, input logic rdy);
        checks++;
        if (done !== d || error !== er || cpu_reset !== cr || in_ready !== rdy) begin
            errors++;
            $display("FAIL %s done/error/cpu_reset/in_ready=%b%b%b%b required=%b%b%b%b",
                     name, done, error, cpu_reset, in_ready, d, er, cr, rdy);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 10'h000 ||
            imem_wdata !== 32'h0 || cpu_reset !== 1'b1 || done !== 1'b0 ||
            error !== 1'b0 || word_count !== 16'h0) begin
            errors++;
            $display("FAIL %s rdy=%b we=%b addr=%h wdata=%h cpu_reset=%b done=%b error=%b wc=%h required reset values",
                     name, in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, word_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset_state");
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        check_reset_values("idle_ignores_valid");
    endtask

    task automatic test_two_word();
        set_two_word();
        pulse_start();
        check_status("two_word_started", 1'b0, 1'b0, 1'b1, 1'b1);
        send_stream(2, 1'b0, 1'b0, -1, -1);
        check_status("two_word_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (word_count !== 16'd2) begin
            errors++;
            $display("FAIL two_word_count got=%0d required=2", word_count);
        end
        check_drained("two_word_writes");
    endtask

    task automatic test_bad_checksum();
        set_two_word();
        pulse_start();
        send_stream(2, 1'b0, 1'b1, -1, -1);
        check_status("bad_checksum", 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("bad_checksum_writes");
    endtask

    task automatic test_zero_length();
        pulse_start();
        check_status("zero_from_error", 1'b0, 1'b0, 1'b1, 1'b1);
        send_stream(0, 1'b0, 1'b0, -1, -1);
        check_status("zero_length_ok", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("zero_length_no_writes");
        pulse_start();
        send_stream(0, 1'b0, 1'b1, -1, -1);
        check_status("zero_length_badchk", 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("zero_length_bad_no_writes");
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        check_status("overflow_error", 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (word_count !== 16'd1025) begin
            errors++;
            $display("FAIL overflow_count got=%0d required=1025", word_count);
        end
        check_drained("overflow_no_writes");
    endtask

    task automatic test_full_capacity();
        for (int i = 0; i < 1024; i++) payload[i] = $urandom;
        last_addr = 10'h000;
        pulse_start();
        send_stream(1024, 1'b0, 1'b0, -1, -1);
        check_status("full_capacity_done", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("full_capacity_writes");
        checks++;
        if (last_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL full_capacity_last_addr got=%h required=3ff", last_addr);
        end
    endtask

    task automatic test_gapped_restart();
        set_two_word();
        pulse_start();
        send_stream(2, 1'b1, 1'b0, 3, -1);
        check_status("gapped_done", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("gapped_writes");
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        pulse_start();
        send_stream(2, 1'b0, 1'b0, -1, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("mid_load_reset");
        check_drained("mid_load_reset_writes");
        checks++;
        if (written[1] !== 1'b0 || written[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_load_written w0=%b w1=%b required w0=1 w1=0", written[0], written[1]);
        end
        pulse_start();
        send_stream(2, 1'b0, 1'b0, -1, -1);
        check_status("fresh_load_done", 1'b1, 1'b0, 1'b0, 1'b0);
        check_drained("fresh_load_writes");
    endtask

    task automatic test_reload_from_done();
        pulse_start();
        check_status("reload_start", 1'b0, 1'b0, 1'b1, 1'b1);
        payload[0] = 32'h00100513;
        send_stream(1, 1'b0, 1'b0, -1, -1);
        check_status("reload_done", 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (word_count !== 16'd1) begin
            errors++;
            $display("FAIL reload_count got=%0d required=1", word_count);
        end
        check_drained("reload_writes");
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_full_capacity();
        test_gapped_restart();
        test_reload_from_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
